// File: rtl/gen_transform_pipe_if.sv
// Stream handshake bundle for gen_transform_pipe.
// The master side drives the upstream word and the downstream ready.
// The slave side (the pipeline) returns the input ready and the result word.
// WIDTH must match the WIDTH of the gen_transform_pipe it connects to.
interface gen_transform_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/gen_transform_pipe.sv
// gen_transform_pipe: fixed-coefficient transform (multiply by COEF or add
// OFFSET, chosen by MODE at elaboration) followed by a STAGES-deep elastic
// pipeline with valid/ready on both sides and an overflow flag per word.
// Optional feature macro: GEN_TRANSFORM_PIPE_SAT_EN -- when defined, an
// overflowing result is clamped to all-ones instead of wrapping.
module gen_transform_pipe #(
   parameter int          WIDTH  = 8,
   parameter int          MODE   = 1,
   parameter int unsigned COEF   = 3,
   parameter int unsigned OFFSET = 5,
   parameter int          STAGES = 2
) (
   input logic                clk,
   input logic                rst_n,
   gen_transform_pipe_if.slave bus
);

   // Full-precision result width: product needs 2*WIDTH, sum needs one carry bit.
   localparam int FW = (MODE == 1) ? 2 * WIDTH : WIDTH + 1;

   generate
      if (MODE != 0 && MODE != 1) begin : g_bad_mode
         $error("gen_transform_pipe: MODE must be 0 or 1");
      end
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("gen_transform_pipe: STAGES must be in 1..4");
      end
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $error("gen_transform_pipe: WIDTH must be in 2..32");
      end
      if ((COEF >> WIDTH) != 0 || (OFFSET >> WIDTH) != 0) begin : g_bad_const
         $error("gen_transform_pipe: COEF and OFFSET must fit in WIDTH bits");
      end
   endgenerate

   // Narrow a full-precision result to WIDTH bits; MSB of the return is ovf.
   function automatic logic [WIDTH:0] fit_result(input logic [FW-1:0] full);
      logic ovf;
      ovf = |full[FW-1:WIDTH];
`ifdef GEN_TRANSFORM_PIPE_SAT_EN
      return {ovf, (ovf ? {WIDTH{1'b1}} : full[WIDTH-1:0])};
`else
      return {ovf, full[WIDTH-1:0]};
`endif
   endfunction

   logic [FW-1:0]    full_w;
   logic [WIDTH:0]   fit_w;
   logic [WIDTH-1:0] res_data_w;
   logic             res_ovf_w;

   generate
      if (MODE == 1) begin : g_mul
         assign full_w = FW'(bus.in_data) * FW'(COEF);
      end else begin : g_add
         assign full_w = FW'(bus.in_data) + FW'(OFFSET);
      end
   endgenerate

   assign fit_w      = fit_result(full_w);
   assign res_ovf_w  = fit_w[WIDTH];
   assign res_data_w = fit_w[WIDTH-1:0];

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] ovf_q, ovf_d;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES:0]   rdy;

   // Ready chain: a stage can load when it is empty or its successor advances.
   always_comb begin
      rdy[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !v_q[k] || rdy[k+1];
      end
   end

   // Next-state: each ready stage takes its upstream valid; payload moves only with a valid word.
   always_comb begin
      v_d    = v_q;
      ovf_d  = ovf_q;
      data_d = data_q;
      if (rdy[0]) begin
         v_d[0] = bus.in_valid;
         if (bus.in_valid) begin
            data_d[0] = res_data_w;
            ovf_d[0]  = res_ovf_w;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (rdy[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               data_d[k] = data_q[k-1];
               ovf_d[k]  = ovf_q[k-1];
            end
         end
      end
   end

   // Stage registers; reset discards every in-flight word at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         ovf_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         v_q    <= v_d;
         ovf_q  <= ovf_d;
         data_q <= data_d;
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.out_data  = data_q[STAGES-1];
   assign bus.out_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_gen_transform_pipe.sv
// Bench for gen_transform_pipe: three instances (x3 with 2 stages, +5 with
// 1 stage, x3 with 4 stages) exercised by directed tables, hand-written
// backpressure/reset sequences and a random valid/ready scoreboard run.
module tb_gen_transform_pipe;

`ifdef GEN_TRANSFORM_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_data;
      logic       exp_ovf;
   } vec_t;

   logic clk;
   logic rst_n;

   int n_vec = 0;
   int n_bad = 0;

   gen_transform_pipe_if #(.WIDTH(8)) a_if ();
   gen_transform_pipe_if #(.WIDTH(8)) b_if ();
   gen_transform_pipe_if #(.WIDTH(8)) c_if ();

   gen_transform_pipe #(.WIDTH(8), .MODE(1), .COEF(3), .OFFSET(5), .STAGES(2)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if)
   );
   gen_transform_pipe #(.WIDTH(8), .MODE(0), .COEF(3), .OFFSET(5), .STAGES(1)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if)
   );
   gen_transform_pipe #(.WIDTH(8), .MODE(1), .COEF(3), .OFFSET(5), .STAGES(4)) u_c (
      .clk(clk), .rst_n(rst_n), .bus(c_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference arithmetic for the x3 instances: {ovf, data}.
   function automatic logic [8:0] model_mul3(input logic [7:0] d);
      logic [15:0] f;
      f = 16'(d) * 16'd3;
      if (f[15:8] != 8'd0) return {1'b1, (SAT ? 8'hFF : f[7:0])};
      return {1'b0, f[7:0]};
   endfunction

   vec_t va [6];
   vec_t vb [3];
   logic [8:0] sb [$];

   initial begin
      // x3, 2 stages: single beats
      va[0] = '{8'd10,  8'd30,                     1'b0};
      va[1] = '{8'd100, (SAT ? 8'd255 : 8'd44),    1'b1};
      va[2] = '{8'd0,   8'd0,                      1'b0};
      va[3] = '{8'd85,  8'd255,                    1'b0};
      va[4] = '{8'd86,  (SAT ? 8'd255 : 8'd2),     1'b1};
      va[5] = '{8'd255, (SAT ? 8'd255 : 8'hFD),    1'b1};
      // +5, 1 stage: back-to-back stream
      vb[0] = '{8'd250, 8'd255,                    1'b0};
      vb[1] = '{8'd251, (SAT ? 8'd255 : 8'd0),     1'b1};
      vb[2] = '{8'd252, (SAT ? 8'd255 : 8'd1),     1'b1};

      rst_n = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
      c_if.in_valid = 1'b0; c_if.in_data = '0; c_if.out_ready = 1'b0;

      // Reset state
      #2;
      chk("rst_a_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("rst_a_out_data",  32'(a_if.out_data),  32'd0);
      chk("rst_a_out_ovf",   32'(a_if.out_ovf),   32'd0);
      chk("rst_a_in_ready",  32'(a_if.in_ready),  32'd1);
      chk("rst_b_out_valid", 32'(b_if.out_valid), 32'd0);
      chk("rst_b_in_ready",  32'(b_if.in_ready),  32'd1);
      chk("rst_c_out_valid", 32'(c_if.out_valid), 32'd0);
      chk("rst_c_in_ready",  32'(c_if.in_ready),  32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single beats through the 2-stage x3 unit: valid exactly one cycle, after edge N+1
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         a_if.in_valid = 1'b1; a_if.in_data = va[i].din; a_if.out_ready = 1'b1;
         @(negedge clk);
         chk("a_in_ready_idle", 32'(a_if.in_ready), 32'd1);
         @(posedge clk); #1;
         a_if.in_valid = 1'b0; a_if.in_data = 8'h5A;
         @(negedge clk);
         chk("a_valid_early", 32'(a_if.out_valid), 32'd0);
         @(negedge clk);
         chk("a_valid", 32'(a_if.out_valid), 32'd1);
         chk("a_data",  32'(a_if.out_data),  32'(va[i].exp_data));
         chk("a_ovf",   32'(a_if.out_ovf),   32'(va[i].exp_ovf));
         @(negedge clk);
         chk("a_valid_once", 32'(a_if.out_valid), 32'd0);
      end

      // Back-to-back stream through the 1-stage +5 unit
      @(posedge clk); #1;
      b_if.in_valid = 1'b1; b_if.in_data = vb[0].din; b_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i < 2) b_if.in_data = vb[i+1].din;
         else       b_if.in_valid = 1'b0;
         @(negedge clk);
         chk("b_valid", 32'(b_if.out_valid), 32'd1);
         chk("b_data",  32'(b_if.out_data),  32'(vb[i].exp_data));
         chk("b_ovf",   32'(b_if.out_ovf),   32'(vb[i].exp_ovf));
      end
      @(negedge clk);
      chk("b_valid_end", 32'(b_if.out_valid), 32'd0);

      // Backpressure on the 2-stage unit: absorbs exactly 2 words, then stalls
      @(posedge clk); #1;
      a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 8'd1;
      @(negedge clk);
      chk("bp_in_ready_0", 32'(a_if.in_ready), 32'd1);
      @(posedge clk); #1;
      a_if.in_data = 8'd2;
      @(negedge clk);
      chk("bp_in_ready_1", 32'(a_if.in_ready), 32'd1);
      @(posedge clk); #1;
      a_if.in_data = 8'd3;
      @(negedge clk);
      chk("bp_in_ready_full", 32'(a_if.in_ready),  32'd0);
      chk("bp_out_valid",     32'(a_if.out_valid), 32'd1);
      chk("bp_out_data",      32'(a_if.out_data),  32'd3);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a_if.in_data = 8'hAA;
         @(negedge clk);
         chk("bp_stall_valid", 32'(a_if.out_valid), 32'd1);
         chk("bp_stall_data",  32'(a_if.out_data),  32'd3);
         chk("bp_stall_ready", 32'(a_if.in_ready),  32'd0);
      end
      @(posedge clk); #1;
      a_if.in_data = 8'd3; a_if.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_full_pass_ready", 32'(a_if.in_ready), 32'd1);
      chk("bp_rel_data0",       32'(a_if.out_data), 32'd3);
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_rel_valid1", 32'(a_if.out_valid), 32'd1);
      chk("bp_rel_data1",  32'(a_if.out_data),  32'd6);
      @(negedge clk);
      chk("bp_rel_valid2", 32'(a_if.out_valid), 32'd1);
      chk("bp_rel_data2",  32'(a_if.out_data),  32'd9);
      @(negedge clk);
      chk("bp_drained", 32'(a_if.out_valid), 32'd0);

      // Reset mid-stream: two words in flight are discarded
      @(posedge clk); #1;
      a_if.out_ready = 1'b0; a_if.in_valid = 1'b1; a_if.in_data = 8'd4;
      @(posedge clk); #1;
      a_if.in_data = 8'd5;
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("mrst_loaded_data",  32'(a_if.out_data), 32'd12);
      chk("mrst_loaded_ready", 32'(a_if.in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("mrst_out_data",  32'(a_if.out_data),  32'd0);
      chk("mrst_out_ovf",   32'(a_if.out_ovf),   32'd0);
      chk("mrst_in_ready",  32'(a_if.in_ready),  32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mrst_no_stale", 32'(a_if.out_valid), 32'd0);
      end

      // Random valid/ready on the 4-stage unit, 1000 words, in-order scoreboard
      begin
         int sent;
         int recv;
         int cyc;
         logic [8:0] exp_w;
         sent = 0; recv = 0; cyc = 0;
         while (recv < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            c_if.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            c_if.in_data   = 8'($urandom);
            c_if.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (c_if.in_valid && c_if.in_ready) begin
               sb.push_back(model_mul3(c_if.in_data));
               sent++;
            end
            if (c_if.out_valid && c_if.out_ready) begin
               if (sb.size() == 0) begin
                  chk("rnd_unexpected_word", 32'(recv), 32'(sent));
               end else begin
                  exp_w = sb.pop_front();
                  chk("rnd_word", 32'({c_if.out_ovf, c_if.out_data}), 32'(exp_w));
               end
               recv++;
            end
            cyc++;
         end
         c_if.in_valid = 1'b0;
         c_if.out_ready = 1'b1;
         chk("rnd_recv_count", 32'(recv), 32'd1000);
         chk("rnd_sent_count", 32'(sent), 32'd1000);
         chk("rnd_sb_empty",   32'(sb.size()), 32'd0);
         repeat (6) @(negedge clk);
         chk("rnd_idle_valid", 32'(c_if.out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
